// File: rtl/apb_i2c_bridge.sv
// APB slave fronting a 16-bit I2C core bus plus a local interrupt block (RIS/IM/MIS/ICR/EDGE).
// Latency: local registers complete in the first ACCESS cycle; core accesses complete in the 3rd ACCESS cycle at best.
// Backpressure: PREADY is held low while the core access waits for wb_ack_i or for the timeout.
module apb_i2c_bridge #(
  parameter int NUM_FLAGS = 9,
  parameter int WB_ADR_W  = 3,
  parameter int TIMEOUT   = 64
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [31:0]          PADDR,
  input  logic [31:0]          PWDATA,
  output logic                 PREADY,
  output logic [31:0]          PRDATA,
  output logic                 PSLVERR,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [WB_ADR_W-1:0]  wb_adr_o,
  output logic [15:0]          wb_dat_o,
  input  logic [15:0]          wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic [NUM_FLAGS-1:0] flags_i,
  output logic                 irq_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam int PAD = 32 - NUM_FLAGS;

  logic [1:0]           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [WB_ADR_W-1:0]  adr_q, adr_d;
  logic [15:0]          wdat_q, wdat_d;
  logic [15:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [NUM_FLAGS-1:0] flag_q, im_q, edge_q, ris_q, ris_d, edge_d;
  logic [NUM_FLAGS-1:0] rise, clr, ris, mis, wdat;
  logic                 irq_q;

  logic                 access, loc_win, loc_acc, core_start;
  logic                 im_we, icr_we, edge_we, loc_hit;
  logic [31:0]          loc_rdata;
  logic                 unused_bits;

  assign access     = PSEL & PENABLE;
  assign loc_win    = (PADDR[15:8] == 8'h0F);
  assign loc_acc    = access & loc_win;
  assign core_start = access & ~loc_win & (state_q == S_IDLE);
  assign wdat       = PWDATA[NUM_FLAGS-1:0];
  assign im_we      = loc_acc & PWRITE & (PADDR[7:0] == 8'h04);
  assign icr_we     = loc_acc & PWRITE & (PADDR[7:0] == 8'h0C);
  assign edge_we    = loc_acc & PWRITE & (PADDR[7:0] == 8'h10);
  assign unused_bits = ^{PADDR[31:16], PWDATA[31:16]};

  // Core-window bridge: launch on ACCESS, wait for ack or timeout, then one response cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (core_start) begin
          state_d = S_WAIT;
          cyc_d   = 1'b1;
          we_d    = PWRITE;
          adr_d   = PADDR[WB_ADR_W:1];
          wdat_d  = PWDATA[15:0];
          cnt_d   = 8'd0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (wb_ack_i) begin
          rdata_d = wb_dat_i;
          cyc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = 16'h0000;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Interrupt status: edge bits are sticky (set beats clear), level bits follow the flag;
  // any change of a bit's EDGE mode drops its sticky state.
  always_comb begin
    rise   = flags_i & ~flag_q;
    clr    = {NUM_FLAGS{icr_we}} & wdat;
    edge_d = edge_we ? wdat : edge_q;
    ris_d  = edge_q & edge_d & ((ris_q & ~clr) | rise);
    ris    = (edge_q & ris_q) | (~edge_q & flags_i);
    mis    = ris & im_q;
  end

  // Local register read mux; undecoded offsets flag an error.
  always_comb begin
    loc_hit   = 1'b1;
    loc_rdata = 32'h0;
    case (PADDR[7:0])
      8'h00:   loc_rdata = {{PAD{1'b0}}, ris};
      8'h04:   loc_rdata = {{PAD{1'b0}}, im_q};
      8'h08:   loc_rdata = {{PAD{1'b0}}, mis};
      8'h0C:   loc_rdata = 32'h0;
      8'h10:   loc_rdata = {{PAD{1'b0}}, edge_q};
      default: begin
        loc_hit   = 1'b0;
        loc_rdata = 32'hDEADBEEF;
      end
    endcase
  end

  // APB response: core response cycle or zero-wait local access; forced quiet during reset.
  always_comb begin
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0;
    if (PRESETn) begin
      if (state_q == S_RESP) begin
        PREADY  = 1'b1;
        PSLVERR = err_q;
        PRDATA  = {16'h0, rdata_q};
      end else if (loc_acc) begin
        PREADY  = 1'b1;
        PSLVERR = ~loc_hit;
        PRDATA  = loc_rdata;
      end
    end
  end

  // State and register update.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= 16'h0;
      rdata_q <= 16'h0;
      err_q   <= 1'b0;
      flag_q  <= '0;
      im_q    <= '0;
      edge_q  <= '0;
      ris_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      flag_q  <= flags_i;
      if (im_we) im_q <= wdat;
      edge_q  <= edge_d;
      ris_q   <= ris_d;
      irq_q   <= |mis;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = wdat_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_apb_i2c_bridge.sv
// Directed bench for apb_i2c_bridge: local register table plus core-bus and interrupt sequences.
module tb_apb_i2c_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [2:0]  wb_adr_o;
  logic [15:0] wb_dat_o, wb_dat_i;
  logic        wb_ack_i;
  logic [8:0]  flags_i;
  logic        irq_o;

  int checks = 0;
  int failures = 0;

  apb_i2c_bridge #(.NUM_FLAGS(9), .WB_ADR_W(3), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .flags_i(flags_i), .irq_o(irq_o)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic apb_local(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output logic rdy);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = {16'h0, addr}; PWDATA = wd;
    tick();
    PENABLE = 1'b1;
    @(negedge PCLK);
    rdy = PREADY; rd = PRDATA; er = PSLVERR;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr_reg(input logic [15:0] addr, input logic [31:0] wd);
    logic [31:0] rd; logic er, rdy;
    apb_local(1'b1, addr, wd, rd, er, rdy);
    chk($sformatf("wr_rdy_%h", addr), rdy, 1);
  endtask

  task automatic rd_reg(input string name, input logic [15:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic er, rdy;
    apb_local(1'b0, addr, 32'h0, rd, er, rdy);
    chk(name, rd, exp);
  endtask

  task automatic core_xfer(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                           input logic [15:0] ack_data, input int ack_at, input bit stray,
                           output int rdy_cyc, output int cyc_cnt, output logic [31:0] rdata,
                           output logic err, output logic [2:0] adr, output logic we,
                           output logic [15:0] dat);
    rdy_cyc = 0; cyc_cnt = 0; rdata = 32'hX; err = 1'bX; adr = 3'h0; we = 1'b0; dat = 16'h0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = {16'h0, addr}; PWDATA = wd;
    wb_dat_i = ack_data;
    tick();
    PENABLE = 1'b1;
    for (int n = 1; n <= 20 && rdy_cyc == 0; n++) begin
      wb_ack_i = ((ack_at != 0) && (n == ack_at + 1)) || (stray && n == 1);
      @(negedge PCLK);
      if (wb_cyc_o) begin
        if (cyc_cnt == 0) begin adr = wb_adr_o; we = wb_we_o; dat = wb_dat_o; end
        cyc_cnt++;
      end
      if (PREADY) begin rdy_cyc = n; rdata = PRDATA; err = PSLVERR; end
      tick();
    end
    wb_ack_i = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pready"}, PREADY, 0);
    chk({tag, "_pslverr"}, PSLVERR, 0);
    chk({tag, "_prdata"}, PRDATA, 0);
    chk({tag, "_cyc"}, wb_cyc_o, 0);
    chk({tag, "_stb"}, wb_stb_o, 0);
    chk({tag, "_we"}, wb_we_o, 0);
    chk({tag, "_adr"}, wb_adr_o, 0);
    chk({tag, "_dat"}, wb_dat_o, 0);
    chk({tag, "_irq"}, irq_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, cc; logic [31:0] rdat; logic er, we; logic [2:0] adr; logic [15:0] dat;
    logic [31:0] rd; logic rdy; int stray_rdy;

    // Table: flags held at 0x104, EDGE starts 0 (all level)
    tbl[0]  = '{0, 16'h0F00, 32'h0,        1, 32'h0000_0104, 0};
    tbl[1]  = '{0, 16'h0F04, 32'h0,        1, 32'h0,         0};
    tbl[2]  = '{1, 16'h0F04, 32'hFFFF_FF00, 0, 32'h0,        0};
    tbl[3]  = '{0, 16'h0F04, 32'h0,        1, 32'h0000_0100, 0};
    tbl[4]  = '{0, 16'h0F08, 32'h0,        1, 32'h0000_0100, 0};
    tbl[5]  = '{1, 16'h0F0C, 32'h0000_01FF, 0, 32'h0,        0};
    tbl[6]  = '{0, 16'h0F00, 32'h0,        1, 32'h0000_0104, 0};
    tbl[7]  = '{0, 16'h0F0C, 32'h0,        1, 32'h0,         0};
    tbl[8]  = '{0, 16'h0F20, 32'h0,        1, 32'hDEAD_BEEF, 1};
    tbl[9]  = '{1, 16'h0F14, 32'h0000_01FF, 0, 32'h0,        1};
    tbl[10] = '{0, 16'h0F10, 32'h0,        1, 32'h0,         0};
    tbl[11] = '{1, 16'h0F10, 32'h0000_0001, 0, 32'h0,        0};
    tbl[12] = '{0, 16'h0F10, 32'h0,        1, 32'h0000_0001, 0};
    tbl[13] = '{0, 16'h0F00, 32'h0,        1, 32'h0000_0104, 0};

    // Reset with a local access presented: everything must stay quiet
    PRESETn = 1'b0; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h0F00;
    PWDATA = 32'h0; wb_dat_i = 16'h0; wb_ack_i = 1'b0; flags_i = 9'h104;
    tick(); tick();
    @(negedge PCLK);
    chk_all_zero("reset");
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
    PRESETn = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      apb_local(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, er, rdy);
      chk($sformatf("tbl%0d_pready", i), rdy, 1);
      chk($sformatf("tbl%0d_pslverr", i), er, tbl[i].exp_err);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_prdata", i), rd, tbl[i].exp_rd);
    end

    // Core write, ack in 2nd WAIT cycle
    core_xfer(1'b1, 16'h0004, 32'h0000_00A5, 16'h5555, 2, 1'b0, rc, cc, rdat, er, adr, we, dat);
    chk("cw_ready_cycle", rc, 4);
    chk("cw_pslverr", er, 0);
    chk("cw_adr", adr, 2);
    chk("cw_we", we, 1);
    chk("cw_dat", dat, 16'h00A5);
    chk("cw_cyc_cycles", cc, 2);

    // Core read, ack in 1st WAIT cycle (best case)
    core_xfer(1'b0, 16'h000E, 32'h0, 16'hBEEF, 1, 1'b0, rc, cc, rdat, er, adr, we, dat);
    chk("cr_ready_cycle", rc, 3);
    chk("cr_prdata", rdat, 32'h0000_BEEF);
    chk("cr_pslverr", er, 0);
    chk("cr_adr", adr, 7);
    chk("cr_we", we, 0);
    chk("cr_cyc_cycles", cc, 1);

    // Core read timing out (stray ack while IDLE must be ignored)
    core_xfer(1'b0, 16'h0020, 32'h0, 16'h1234, 0, 1'b1, rc, cc, rdat, er, adr, we, dat);
    chk("to_ready_cycle", rc, 6);
    chk("to_pslverr", er, 1);
    chk("to_prdata", rdat, 0);
    chk("to_cyc_cycles", cc, 4);

    // Stray ack with no transfer: no response
    wb_ack_i = 1'b1; tick(); wb_ack_i = 1'b0;
    stray_rdy = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge PCLK);
      if (PREADY || wb_cyc_o) stray_rdy++;
      tick();
    end
    chk("stray_ack_idle", stray_rdy, 0);

    // Edge-mode pulse on flag 0
    flags_i = 9'h000; tick();
    wr_reg(16'h0F10, 32'h1);
    wr_reg(16'h0F04, 32'h1);
    flags_i = 9'h001; tick();
    flags_i = 9'h000;
    @(negedge PCLK); chk("edge_irq_delay", irq_o, 0);
    tick();
    @(negedge PCLK); chk("edge_irq_set", irq_o, 1);
    tick();
    rd_reg("edge_ris", 16'h0F00, 32'h1);
    rd_reg("edge_mis", 16'h0F08, 32'h1);
    wr_reg(16'h0F0C, 32'h1);
    tick();
    @(negedge PCLK); chk("edge_irq_clr", irq_o, 0);
    tick();
    rd_reg("edge_ris_clr", 16'h0F00, 32'h0);

    // Rising edge in the same cycle as ICR clear: set wins
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0F0C; PWDATA = 32'h1;
    tick();
    PENABLE = 1'b1; flags_i = 9'h001;
    @(negedge PCLK); chk("setwin_pready", PREADY, 1);
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    rd_reg("setwin_ris", 16'h0F00, 32'h1);

    // EDGE mode switching with flag 0 held high
    wr_reg(16'h0F0C, 32'h1);
    rd_reg("hold_no_edge", 16'h0F00, 32'h0);
    wr_reg(16'h0F10, 32'h0);
    rd_reg("edge_to_level", 16'h0F00, 32'h1);
    wr_reg(16'h0F10, 32'h1);
    rd_reg("level_to_edge", 16'h0F00, 32'h0);
    flags_i = 9'h000;

    // Level mode on flag 8
    wr_reg(16'h0F04, 32'h100);
    flags_i = 9'h100;
    rd_reg("lvl_mis", 16'h0F08, 32'h100);
    @(negedge PCLK); chk("lvl_irq_set", irq_o, 1);
    tick();
    flags_i = 9'h000;
    tick(); tick();
    @(negedge PCLK); chk("lvl_irq_clr", irq_o, 0);
    tick();
    rd_reg("lvl_ris_clr", 16'h0F00, 32'h0);

    // Reset during WAIT with irq pending
    flags_i = 9'h102; tick(); tick();
    @(negedge PCLK); chk("pre_rst_irq", irq_o, 1);
    tick();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0006; PWDATA = 32'h0000_7777;
    tick();
    PENABLE = 1'b1;
    tick();
    @(negedge PCLK); chk("pre_rst_cyc", wb_cyc_o, 1);
    PRESETn = 1'b0;
    #1;
    chk_all_zero("rst_wait");
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    tick();
    PRESETn = 1'b1;
    stray_rdy = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge PCLK);
      if (PREADY || wb_cyc_o) stray_rdy++;
      tick();
    end
    chk("rst_no_resume", stray_rdy, 0);

    // Flags already high across reset: EDGE write must not capture them
    rd_reg("post_rst_ris", 16'h0F00, 32'h102);
    wr_reg(16'h0F10, 32'h2);
    rd_reg("post_rst_edge_ris", 16'h0F00, 32'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
